// File: rtl/fifo_read_ctrl_pkg.sv
// fifo_read_ctrl_pkg: shared FIFO read latency and skid depth constants
package fifo_read_ctrl_pkg;
  localparam int READ_LATENCY = 1;
  localparam logic [1:0] SKID_DEPTH = 2'd2;
endpackage

// File: rtl/read_skid_buffer.sv
// read_skid_buffer: 2-entry skid buffer (clk, rst_n, pop, cap/cap_data in, occ/out_valid/out_data out)
module read_skid_buffer
  import fifo_read_ctrl_pkg::*;
#(
  parameter int MEMORY_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pop,
  input  logic                    cap,
  input  logic [MEMORY_WIDTH-1:0] cap_data,
  output logic [1:0]              occ,
  output logic                    out_valid,
  output logic [MEMORY_WIDTH-1:0] out_data
);
  logic [1:0] base;
  logic [MEMORY_WIDTH-1:0] buf0, buf1;
  assign base = occ - {1'b0, pop};
  assign out_valid = occ != 2'd0;
  assign out_data = buf0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occ <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      occ <= base + {1'b0, cap};
      buf0 <= (cap && base == 2'd0) ? cap_data : (pop && occ == SKID_DEPTH) ? buf1 : buf0;
      buf1 <= (cap && base == 2'd1) ? cap_data : buf1;
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(cap && base == SKID_DEPTH));
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: drains fifo_synch (empty/rdata in, r_en out) into a valid/ready stream with delivered-word count
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int MEMORY_WIDTH = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    empty,
  input  logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    r_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MEMORY_WIDTH-1:0] out_data,
  output logic [COUNT_WIDTH-1:0]  xfer_count
);
  logic [1:0] occ;
  logic inflight, pop;
  logic [2:0] level;
  assign pop = out_valid & out_ready;
  // pop only happens with occ>=1, so level cannot underflow
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign r_en = !empty && level < {1'b0, SKID_DEPTH};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight <= 1'b0;
      xfer_count <= '0;
    end else begin
      inflight <= r_en;
      xfer_count <= xfer_count + COUNT_WIDTH'(pop);
    end
  read_skid_buffer #(.MEMORY_WIDTH(MEMORY_WIDTH)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .pop(pop),
    .cap(inflight),
    .cap_data(rdata),
    .occ(occ),
    .out_valid(out_valid),
    .out_data(out_data)
  );
  a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n) !(r_en && empty));
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed self-checking bench with a 1-cycle-latency FIFO model
module tb_fifo_read_ctrl;
  import fifo_read_ctrl_pkg::*;
  logic clk = 0, rst_n = 0, empty = 1, out_ready = 0, r_en, out_valid;
  logic [3:0] rdata = 0, out_data;
  logic [7:0] xfer_count, prev_x;
  logic [3:0] q[$], rx[$];
  int passed = 0, total = 0;
  int issued, popped, max_held, bad_ren, ren_cycles, valid_cycles, wraps, errs;
  fifo_read_ctrl #(.MEMORY_WIDTH(4), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rdata(rdata), .r_en(r_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .xfer_count(xfer_count)
  );
  always #5 clk = ~clk;
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task clear_stats();
    rx.delete();
    issued = 0; popped = 0; max_held = 0; bad_ren = 0;
    ren_cycles = 0; valid_cycles = 0; wraps = 0;
  endtask
  task do_reset();
    rst_n = 0; q.delete(); rdata = 0; empty = 1; out_ready = 0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task push(input logic [3:0] v);
    q.push_back(v);
    empty = 0;
  endtask
  task step();
    logic re;
    #1;
    if (out_valid && out_ready) begin rx.push_back(out_data); popped++; end
    if (r_en && empty) bad_ren++;
    re = r_en;
    if (re) begin issued++; ren_cycles++; end
    if (out_valid) valid_cycles++;
    if (issued - popped > max_held) max_held = issued - popped;
    prev_x = xfer_count;
    @(posedge clk);
    #1;
    if (prev_x == 8'd255 && xfer_count == 8'd0) wraps++;
    if (re && q.size() != 0) rdata = q.pop_front();
    empty = q.size() == 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    do_reset();
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_data", 32'(out_data), 0);
    check("rst xfer", 32'(xfer_count), 0);
    check("rst r_en", 32'(r_en), 0);
    for (int i = 1; i <= 4; i++) push(4'(i));
    out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("t1 r_en c%0d", c), 32'(r_en), 32'(c < 4));
      check($sformatf("t1 valid c%0d", c), 32'(out_valid), 32'(c >= 2));
      if (c >= 2) check($sformatf("t1 data c%0d", c), 32'(out_data), 32'(c - 1));
      step();
    end
    #1 check("t1 xfer", 32'(xfer_count), 4);
    do_reset();
    for (int i = 0; i < 5; i++) push(4'(10 + i));
    repeat (10) step();
    #1;
    check("t2 reads issued", 32'(ren_cycles), 2);
    check("t2 r_en held", 32'(r_en), 0);
    check("t2 out_valid", 32'(out_valid), 1);
    check("t2 out_data", 32'(out_data), 10);
    check("t2 no pops", 32'(rx.size()), 0);
    out_ready = 1;
    repeat (10) step();
    check("t2 rx count", 32'(rx.size()), 5);
    for (int i = 0; i < rx.size(); i++) check($sformatf("t2 rx%0d", i), 32'(rx[i]), 32'(10 + i));
    do_reset();
    for (int i = 0; i < 6; i++) push(4'(10 + i));
    for (int c = 0; c < 30; c++) begin
      out_ready = (c % 2) == 0;
      step();
    end
    check("t3 rx count", 32'(rx.size()), 6);
    for (int i = 0; i < rx.size(); i++) check($sformatf("t3 rx%0d", i), 32'(rx[i]), 32'(10 + i));
    check("t3 held<=2", 32'(max_held <= 2), 1);
    check("t3 r_en while empty", 32'(bad_ren), 0);
    do_reset();
    out_ready = 1;
    repeat (20) step();
    check("t4 idle r_en", 32'(ren_cycles), 0);
    check("t4 idle valid", 32'(valid_cycles), 0);
    push(4'h9);
    #1 check("t4 r_en", 32'(r_en), 1);
    for (int c = 1; c <= READ_LATENCY + 1; c++) begin
      step();
      #1 check($sformatf("t4 valid r+%0d", c), 32'(out_valid), 32'(c == READ_LATENCY + 1));
    end
    check("t4 data", 32'(out_data), 9);
    do_reset();
    for (int i = 0; i < 258; i++) push(4'(i % 16));
    out_ready = 1;
    repeat (265) step();
    check("t5 xfer end", 32'(xfer_count), 2);
    check("t5 wrap", 32'(wraps), 1);
    check("t5 rx count", 32'(rx.size()), 258);
    errs = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] != 4'(i % 16)) errs++;
    check("t5 order errs", 32'(errs), 0);
    do_reset();
    for (int i = 1; i <= 6; i++) push(4'(i));
    out_ready = 1;
    repeat (4) step();
    out_ready = 0;
    step();
    #1;
    check("t6 pre valid", 32'(out_valid), 1);
    check("t6 pre data", 32'(out_data), 3);
    check("t6 pre xfer", 32'(xfer_count), 2);
    check("t6 pre r_en", 32'(r_en), 0);
    #2 rst_n = 0;
    q.delete(); rdata = 0; empty = 1;
    #1;
    check("t6 async valid", 32'(out_valid), 0);
    check("t6 async data", 32'(out_data), 0);
    check("t6 async xfer", 32'(xfer_count), 0);
    @(posedge clk);
    #1 rst_n = 1;
    clear_stats();
    out_ready = 1;
    repeat (5) step();
    check("t6 no stale valid", 32'(valid_cycles), 0);
    push(4'h7);
    repeat (4) step();
    check("t6 post count", 32'(rx.size()), 1);
    if (rx.size() != 0) check("t6 post data", 32'(rx[0]), 7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
